// File: rtl/ltl_monitor_pkg.sv
// ltl_monitor_pkg
//   Shared definitions for the LTL monitor slice: default widths for one
//   automaton cluster's report path and the queued report entry type.
//   No ports; imported by ltl_report_fifo and ltl_report_collector.
package ltl_monitor_pkg;

  localparam int LTL_TS_W        = 32;
  localparam int LTL_NUM_REPORTS = 4;
  localparam int LTL_DEPTH       = 8;
  localparam int LTL_DROP_W      = 8;

  // One queued report: the symbol index it fired on and which report STEs fired.
  typedef struct packed {
    logic [LTL_TS_W-1:0]        ts;
    logic [LTL_NUM_REPORTS-1:0] vec;
  } ltl_report_entry_t;

endpackage

// File: rtl/ltl_report_fifo.sv
// ltl_report_fifo
//   Generic DEPTH x WIDTH synchronous FIFO built from a flop array.
//   Ports:
//     clk      in   clock, rising edge
//     reset    in   asynchronous active-high reset, empties the FIFO
//     clear_i  in   synchronous empty, wins over push/pop
//     push_i   in   write data_i at the tail (accepted when not full or popping)
//     pop_i    in   drop the head entry (ignored when empty)
//     data_i   in   tail write data
//     data_o   out  head entry, all zeros while empty
//     full_o   out  DEPTH entries held
//     empty_o  out  no entries held
module ltl_report_fifo
  import ltl_monitor_pkg::*;
#(
  parameter int WIDTH = LTL_TS_W + LTL_NUM_REPORTS,
  parameter int DEPTH = LTL_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic             doPush;
  logic             doPop;

  // Pointers carry one extra wrap bit: equal means empty, MSB-only difference means full.
  assign empty_o = (wrPtr_q == rdPtr_q);
  assign full_o  = (wrPtr_q[PTR_W-1] != rdPtr_q[PTR_W-1]) &&
                   (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);

  // A push into a full FIFO is still taken when the head leaves in the same cycle.
  assign doPop  = pop_i && !empty_o && !clear_i;
  assign doPush = push_i && (!full_o || doPop) && !clear_i;

  assign data_o = empty_o ? '0 : mem[rdPtr_q[AW-1:0]];

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (clear_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
    end else begin
      if (doPush) wrPtr_d = wrPtr_q + PTR_W'(1);
      if (doPop)  rdPtr_d = rdPtr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  // Storage is not reset; stale slots are never visible because data_o is masked when empty.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/ltl_report_collector.sv
// ltl_report_collector
//   Collects the report vector of one compiled LTL automaton cluster. Every run
//   cycle with a non-zero report vector queues {symbol index, vector}; entries
//   drain over valid/ready. Also keeps sticky seen flags, an overflow flag, a
//   saturating drop counter and a registered interrupt.
//   Ports:
//     clk         in   clock, rising edge
//     reset       in   asynchronous active-high reset (deassertion expected synchronous to clk)
//     run         in   symbol-valid strobe shared with the automaton
//     clear       in   synchronous clear of timestamp, queue, flags and counter
//     report_vec  in   report STE outputs
//     out_valid   out  head entry valid
//     out_ready   in   consumer takes the head when out_valid && out_ready
//     out_ts      out  head entry symbol index
//     out_vec     out  head entry report vector
//     seen        out  sticky OR of all report bits sampled under run
//     overflow    out  sticky, an entry was dropped because the queue was full
//     drop_cnt    out  number of dropped entries, saturating
//     irq         out  registered out_valid || overflow
module ltl_report_collector
  import ltl_monitor_pkg::*;
#(
  parameter int NUM_REPORTS = LTL_NUM_REPORTS,
  parameter int TS_W        = LTL_TS_W,
  parameter int DEPTH       = LTL_DEPTH,
  parameter int DROP_W      = LTL_DROP_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic                   clear,
  input  logic [NUM_REPORTS-1:0] report_vec,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [TS_W-1:0]        out_ts,
  output logic [NUM_REPORTS-1:0] out_vec,
  output logic [NUM_REPORTS-1:0] seen,
  output logic                   overflow,
  output logic [DROP_W-1:0]      drop_cnt,
  output logic                   irq
);

  localparam int ENTRY_W = TS_W + NUM_REPORTS;

  logic [TS_W-1:0]        ts_q, ts_d;
  logic [NUM_REPORTS-1:0] seen_q, seen_d;
  logic                   overflow_q, overflow_d;
  logic [DROP_W-1:0]      dropCnt_q, dropCnt_d;
  logic                   irq_q, irq_d;

  logic                   fifoFull;
  logic                   fifoEmpty;
  logic [ENTRY_W-1:0]     headEntry;
  logic                   reportHit;
  logic                   popFire;
  logic                   dropHit;

  // clear suppresses the report of its own cycle, so it also gates the push request.
  assign reportHit = run && (report_vec != '0) && !clear;
  assign popFire   = out_valid && out_ready && !clear;
  assign dropHit   = reportHit && fifoFull && !popFire;

  ltl_report_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear_i (clear),
    .push_i  (reportHit),
    .pop_i   (popFire),
    .data_i  ({ts_q, report_vec}),
    .data_o  (headEntry),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  assign out_valid = !fifoEmpty;
  assign {out_ts, out_vec} = headEntry;
  assign seen     = seen_q;
  assign overflow = overflow_q;
  assign drop_cnt = dropCnt_q;
  assign irq      = irq_q;

  // Entries carry the pre-increment symbol index; the counter wraps silently.
  always_comb begin
    ts_d       = ts_q;
    seen_d     = seen_q;
    overflow_d = overflow_q;
    dropCnt_d  = dropCnt_q;
    irq_d      = out_valid || overflow_q;
    if (clear) begin
      ts_d       = '0;
      seen_d     = '0;
      overflow_d = 1'b0;
      dropCnt_d  = '0;
      irq_d      = 1'b0;
    end else begin
      if (run) begin
        ts_d   = ts_q + TS_W'(1);
        seen_d = seen_q | report_vec;
      end
      if (dropHit) begin
        overflow_d = 1'b1;
        if (dropCnt_q != '1) dropCnt_d = dropCnt_q + DROP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_q       <= '0;
      seen_q     <= '0;
      overflow_q <= 1'b0;
      dropCnt_q  <= '0;
      irq_q      <= 1'b0;
    end else begin
      ts_q       <= ts_d;
      seen_q     <= seen_d;
      overflow_q <= overflow_d;
      dropCnt_q  <= dropCnt_d;
      irq_q      <= irq_d;
    end
  end

endmodule
